// File: rtl/nf_ahb_pkg.sv
// rtl/nf_ahb_pkg.sv - shared types and AHB encodings for the nf AHB-Lite master
package nf_ahb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // A request is illegal for a reserved size or an address not aligned to its size
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HSIZE_BYTE[1:0]: bad = 1'b0;
            HSIZE_HALF[1:0]: bad = addr_lo[0];
            HSIZE_WORD[1:0]: bad = (addr_lo != 2'b00);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/nf_timeout_cnt.sv
// rtl/nf_timeout_cnt.sv - clear/enable wait counter with terminal-count flag
module nf_timeout_cnt #(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] LAST_CNT = (timeout_cycles == 0) ? '0 : CW'(timeout_cycles - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Terminal count fires on the increment that makes the count reach timeout_cycles
    always_comb begin
        tc = (timeout_cycles != 0) && en && !clr && (cnt_q == LAST_CNT);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nf_ahb_master.sv
// rtl/nf_ahb_master.sv - core request/ack to non-pipelined AHB-Lite single-transfer master
module nf_ahb_master
    import nf_ahb_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [1:0]  size,
    output logic [31:0] rd,
    output logic        req_ack,
    output logic        err,
    output logic [31:0] haddr_m,
    output logic [31:0] hwdata_m,
    input  logic [31:0] hrdata_m,
    output logic        hwrite_m,
    output logic [1:0]  htrans_m,
    output logic [2:0]  hsize_m,
    output logic [2:0]  hburst_m,
    input  logic [1:0]  hresp_m,
    input  logic        hready_m
);

    state_t      state_q,   state_d;
    logic [31:0] wd_q,      wd_d;
    logic [31:0] rd_q,      rd_d;
    logic        req_ack_q, req_ack_d;
    logic        err_q,     err_d;
    logic [31:0] haddr_q,   haddr_d;
    logic [31:0] hwdata_q,  hwdata_d;
    logic        hwrite_q,  hwrite_d;
    logic [1:0]  htrans_q,  htrans_d;
    logic [2:0]  hsize_q,   hsize_d;

    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;
    logic        resp_okay;

    assign resp_okay = (hresp_m == HRESP_OKAY);

    nf_timeout_cnt #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout_cnt (
        .clk    (hclk),
        .resetn (hresetn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc     (cnt_tc)
    );

    // Next-state and registered-output logic for the transfer FSM
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        rd_d      = rd_q;
        req_ack_d = 1'b0;
        err_d     = 1'b0;
        haddr_d   = haddr_q;
        hwdata_d  = hwdata_q;
        hwrite_d  = hwrite_q;
        htrans_d  = htrans_q;
        hsize_d   = hsize_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_illegal(size, addr[1:0])) begin
                        // A held illegal request acks every other cycle so acks never abut
                        if (!req_ack_q) begin
                            req_ack_d = 1'b1;
                            err_d     = 1'b1;
                        end
                    end else begin
                        wd_d     = wd;
                        haddr_d  = addr;
                        hwrite_d = we;
                        hsize_d  = {1'b0, size};
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                if (hready_m) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wd_q;
                    cnt_clr  = 1'b1;
                    state_d  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (hready_m) begin
                    req_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                    if (resp_okay) begin
                        if (!hwrite_q) begin
                            rd_d = hrdata_m;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (hresp_m == HRESP_ERROR) begin
                    state_d = ST_ERR2;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        req_ack_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_ERR2: begin
                if (hready_m) begin
                    req_ack_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            rd_q      <= '0;
            req_ack_q <= 1'b0;
            err_q     <= 1'b0;
            haddr_q   <= '0;
            hwdata_q  <= '0;
            hwrite_q  <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            hsize_q   <= HSIZE_BYTE;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            req_ack_q <= req_ack_d;
            err_q     <= err_d;
            haddr_q   <= haddr_d;
            hwdata_q  <= hwdata_d;
            hwrite_q  <= hwrite_d;
            htrans_q  <= htrans_d;
            hsize_q   <= hsize_d;
        end
    end

    assign rd       = rd_q;
    assign req_ack  = req_ack_q;
    assign err      = err_q;
    assign haddr_m  = haddr_q;
    assign hwdata_m = hwdata_q;
    assign hwrite_m = hwrite_q;
    assign htrans_m = htrans_q;
    assign hsize_m  = hsize_q;
    assign hburst_m = HBURST_SINGLE;

endmodule

// File: tb/tb_nf_ahb_master.sv
// tb/tb_nf_ahb_master.sv - scoreboard testbench for nf_ahb_master
module tb_nf_ahb_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [1:0]  size;
    logic [31:0] rd;
    logic        req_ack;
    logic        err;
    logic [31:0] haddr_m;
    logic [31:0] hwdata_m;
    logic [31:0] hrdata_m;
    logic        hwrite_m;
    logic [1:0]  htrans_m;
    logic [2:0]  hsize_m;
    logic [2:0]  hburst_m;
    logic [1:0]  hresp_m;
    logic        hready_m;

    nf_ahb_master #(
        .timeout_cycles(4)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .req      (req),
        .addr     (addr),
        .wd       (wd),
        .we       (we),
        .size     (size),
        .rd       (rd),
        .req_ack  (req_ack),
        .err      (err),
        .haddr_m  (haddr_m),
        .hwdata_m (hwdata_m),
        .hrdata_m (hrdata_m),
        .hwrite_m (hwrite_m),
        .htrans_m (htrans_m),
        .hsize_m  (hsize_m),
        .hburst_m (hburst_m),
        .hresp_m  (hresp_m),
        .hready_m (hready_m)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rd;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          e0 = 0;
    int          nonseq_cnt = 0;
    logic        prev_ack = 1'b0;
    logic [31:0] model_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic e, input int edge_n);
        exp_t x;
        x.tag    = tag;
        x.err    = e;
        x.rd     = model_rd;
        x.edge_n = edge_n;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] s);
        req  = 1'b1;
        addr = a;
        wd   = d;
        we   = w;
        size = s;
        e0   = cyc + 1;
    endtask

    always @(posedge hclk) cyc <= cyc + 1;

    // Completion monitor: pops the scoreboard on every ack
    always @(negedge hclk) begin
        if (htrans_m == 2'b10) nonseq_cnt++;
        if (req_ack) begin
            if (prev_ack) check_eq("ack_consecutive", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check_eq({x.tag, "_err"}, {31'd0, err}, {31'd0, x.err});
                check_eq({x.tag, "_rd"}, rd, x.rd);
                check_eq({x.tag, "_edge"}, cyc + 1, x.edge_n);
            end
        end
        prev_ack = req_ack;
    end

    initial begin
        hresetn  = 1'b0;
        req      = 1'b0;
        addr     = '0;
        wd       = '0;
        we       = 1'b0;
        size     = 2'd2;
        hrdata_m = '0;
        hresp_m  = 2'b00;
        hready_m = 1'b1;
        tick();
        tick();
        check_eq("rst_htrans", {30'd0, htrans_m}, 32'd0);
        check_eq("rst_haddr", haddr_m, 32'd0);
        check_eq("rst_hwdata", hwdata_m, 32'd0);
        check_eq("rst_ctl", {25'd0, hwrite_m, hsize_m, hburst_m}, 32'd0);
        check_eq("rst_ack", {30'd0, req_ack, err}, 32'd0);
        check_eq("rst_rd", rd, 32'd0);
        hresetn = 1'b1;
        tick();

        // Zero-wait word write
        nonseq_cnt = 0;
        start(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'd2);
        push_exp("wr0", 1'b0, e0 + 3);
        tick();
        req = 1'b0;
        check_eq("wr0_htrans_a", {30'd0, htrans_m}, 32'h2);
        check_eq("wr0_haddr", haddr_m, 32'h0000_0010);
        check_eq("wr0_ctl", {25'd0, hwrite_m, hsize_m, hburst_m}, {25'd0, 1'b1, 3'b010, 3'b000});
        tick();
        check_eq("wr0_htrans_d", {30'd0, htrans_m}, 32'h0);
        check_eq("wr0_hwdata", hwdata_m, 32'hDEAD_BEEF);
        tick();
        check_eq("wr0_nonseq_cycles", nonseq_cnt, 1);
        tick();

        // Read with two wait states
        start(32'h0000_0020, 32'h0, 1'b0, 2'd2);
        model_rd = 32'h1234_5678;
        push_exp("rd2w", 1'b0, e0 + 5);
        tick();
        req = 1'b0;
        tick();
        hready_m = 1'b0;
        tick();
        tick();
        hready_m = 1'b1;
        hrdata_m = 32'h1234_5678;
        tick();
        hrdata_m = 32'h0;
        tick();

        // Two-cycle ERROR response on a halfword write
        start(32'h0000_0032, 32'h0000_AAAA, 1'b1, 2'd1);
        push_exp("err2", 1'b1, e0 + 4);
        tick();
        req = 1'b0;
        tick();
        hready_m = 1'b0;
        hresp_m  = 2'b01;
        tick();
        hready_m = 1'b1;
        tick();
        hresp_m = 2'b00;
        tick();

        // ERROR with hready high straight from the data phase
        start(32'h0000_0041, 32'h0, 1'b0, 2'd0);
        push_exp("err1", 1'b1, e0 + 3);
        tick();
        req = 1'b0;
        tick();
        hresp_m = 2'b01;
        tick();
        hresp_m = 2'b00;
        tick();

        // Illegal requests: no bus activity, ack at edge 1 with err
        nonseq_cnt = 0;
        start(32'h0000_0003, 32'h0, 1'b0, 2'd1);
        push_exp("ill_half", 1'b1, e0 + 1);
        tick();
        req = 1'b0;
        tick();
        start(32'h0000_0002, 32'h0, 1'b1, 2'd2);
        push_exp("ill_word", 1'b1, e0 + 1);
        tick();
        req = 1'b0;
        tick();
        start(32'h0000_0000, 32'h0, 1'b0, 2'd3);
        push_exp("ill_size3", 1'b1, e0 + 1);
        push_exp("ill_size3_held", 1'b1, e0 + 3);
        tick();
        tick();
        tick();
        tick();
        req = 1'b0;
        tick();
        check_eq("ill_nonseq_cycles", nonseq_cnt, 0);

        // Hung slave: timeout after four wait cycles
        start(32'h0000_0050, 32'h0, 1'b0, 2'd2);
        push_exp("tmo", 1'b1, e0 + 6);
        tick();
        req = 1'b0;
        tick();
        hready_m = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        check_eq("tmo_htrans", {30'd0, htrans_m}, 32'h0);
        hready_m = 1'b1;
        tick();

        // hready arrives on the edge the timeout would fire: normal completion
        start(32'h0000_0054, 32'h0, 1'b0, 2'd2);
        model_rd = 32'hA5A5_0F0F;
        push_exp("tmo_race", 1'b0, e0 + 6);
        tick();
        req = 1'b0;
        tick();
        hready_m = 1'b0;
        tick();
        tick();
        tick();
        hready_m = 1'b1;
        hrdata_m = 32'hA5A5_0F0F;
        tick();
        hrdata_m = 32'h0;
        tick();

        // Back-to-back writes with req held through the ack cycle
        start(32'h0000_0060, 32'h1111_2222, 1'b1, 2'd2);
        push_exp("b2b_a", 1'b0, e0 + 3);
        push_exp("b2b_b", 1'b0, e0 + 6);
        tick();
        tick();
        tick();
        addr = 32'h0000_0044;
        wd   = 32'h0000_0055;
        tick();
        req = 1'b0;
        check_eq("b2b_haddr", haddr_m, 32'h0000_0044);
        check_eq("b2b_htrans", {30'd0, htrans_m}, 32'h2);
        tick();
        check_eq("b2b_hwdata", hwdata_m, 32'h0000_0055);
        tick();
        tick();

        // Reset during the data phase with req held
        start(32'h0000_0080, 32'hCAFE_F00D, 1'b1, 2'd2);
        tick();
        tick();
        hready_m = 1'b0;
        hresetn  = 1'b0;
        tick();
        model_rd = 32'h0;
        check_eq("mid_rst_htrans", {30'd0, htrans_m}, 32'h0);
        check_eq("mid_rst_haddr", haddr_m, 32'h0);
        check_eq("mid_rst_hwdata", hwdata_m, 32'h0);
        check_eq("mid_rst_ctl", {25'd0, hwrite_m, hsize_m, hburst_m}, 32'd0);
        check_eq("mid_rst_ack", {30'd0, req_ack, err}, 32'd0);
        check_eq("mid_rst_rd", rd, 32'h0);
        hresetn  = 1'b1;
        hready_m = 1'b1;
        e0 = cyc + 1;
        push_exp("post_rst", 1'b0, e0 + 3);
        tick();
        req = 1'b0;
        check_eq("post_rst_htrans", {30'd0, htrans_m}, 32'h2);
        check_eq("post_rst_haddr", haddr_m, 32'h0000_0080);
        tick();
        tick();
        tick();

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
